asp_net_endpoint: RTL and testbench

- Network-side link partner of the ASP.
- Receive path: consumes tagged words the ASP drives onto the network, recomputes the keyed tag, and returns ACK on a match.
- Transmit path: originates tagged words toward the ASP, waits for the ASP's ACK, and retransmits on timeout up to a retry limit.
- Used as the far-end model in system benches and as the endpoint RTL in a two-node link.

---
 rtl/asp_net_pkg.sv | 36 +++
 rtl/asp_net_tag_check.sv | 62 ++++++
 rtl/asp_net_endpoint.sv | 132 +++++++++++++
 tb/tb_asp_net_endpoint.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asp_net_pkg.sv
// Shared types, constants and the keyed tag function for the ASP network endpoint.
package asp_net_pkg;

    localparam int KEY_SIZE      = 16;
    localparam int MAX_DATA_SIZE = 256;
    localparam int MAX_TAG_SIZE  = 32;
    localparam int DIDX_W        = $clog2(MAX_DATA_SIZE);
    localparam int TIDX_W        = $clog2(MAX_TAG_SIZE);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT_ACK
    } tx_state_t;

    // Folds the payload into tag_size-bit chunks by XOR, then mixes in both key bytes.
    // Operates on maximum-width vectors so any DATA_SIZE/TAG_SIZE pair can share it;
    // callers zero-extend the data and truncate the result to their own widths.
    function automatic logic [MAX_TAG_SIZE-1:0] calc_tag(
        input logic [MAX_DATA_SIZE-1:0] data,
        input logic [KEY_SIZE-1:0]      key,
        input int                       data_size,
        input int                       tag_size
    );
        logic [MAX_TAG_SIZE-1:0] acc;
        acc = '0;
        for (int b = 0; b < MAX_DATA_SIZE; b++) begin
            if (b < data_size) begin
                acc[TIDX_W'(b % tag_size)] = acc[TIDX_W'(b % tag_size)] ^ data[DIDX_W'(b)];
            end
        end
        acc[7:0] = acc[7:0] ^ key[7:0] ^ key[15:8];
        return acc;
    endfunction

endpackage

// File: rtl/asp_net_tag_check.sv
// Registered receive stage: recomputes the keyed tag of each incoming word and
// turns the comparison into one-cycle ACK / data-valid / tag-error pulses.
module asp_net_tag_check
    import asp_net_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int TAG_SIZE  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [KEY_SIZE-1:0]           key_in,
    input  logic                          rx_valid_in,
    input  logic [DATA_SIZE+TAG_SIZE-1:0] rx_data_tag_in,
    output logic                          ack_out,
    output logic [DATA_SIZE-1:0]          rx_data_out,
    output logic                          rx_data_valid_out,
    output logic                          rx_tag_error_out
);

    logic [DATA_SIZE-1:0] rx_data;
    logic [TAG_SIZE-1:0]  rx_tag;
    logic [TAG_SIZE-1:0]  exp_tag;
    logic                 tag_match;

    logic                 ack_d, ack_q;
    logic                 valid_d, valid_q;
    logic                 err_d, err_q;
    logic [DATA_SIZE-1:0] data_d, data_q;

    // Split the incoming word, compare its tag, and decide next-cycle pulses and held payload.
    always_comb begin
        rx_data   = rx_data_tag_in[DATA_SIZE+TAG_SIZE-1:TAG_SIZE];
        rx_tag    = rx_data_tag_in[TAG_SIZE-1:0];
        exp_tag   = TAG_SIZE'(calc_tag(MAX_DATA_SIZE'(rx_data), key_in, DATA_SIZE, TAG_SIZE));
        tag_match = (exp_tag == rx_tag);
        ack_d     = rx_valid_in && tag_match;
        valid_d   = rx_valid_in && tag_match;
        err_d     = rx_valid_in && !tag_match;
        data_d    = ack_d ? rx_data : data_q;
    end

    // Register the compare results; a low reset clears every output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            ack_q   <= ack_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign ack_out           = ack_q;
    assign rx_data_valid_out = valid_q;
    assign rx_tag_error_out  = err_q;
    assign rx_data_out       = data_q;

endmodule

// File: rtl/asp_net_endpoint.sv
// Network-side link partner of the ASP: an independent tag-checking receive stage
// plus a transmit FSM that sends tagged words and retransmits on ACK timeout.
module asp_net_endpoint
    import asp_net_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int TAG_SIZE    = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [KEY_SIZE-1:0]           key_in,
    input  logic                          rx_valid_in,
    input  logic [DATA_SIZE+TAG_SIZE-1:0] rx_data_tag_in,
    output logic                          ack_out,
    output logic [DATA_SIZE-1:0]          rx_data_out,
    output logic                          rx_data_valid_out,
    output logic                          rx_tag_error_out,
    input  logic                          tx_req_in,
    input  logic [DATA_SIZE-1:0]          tx_data_in,
    output logic                          tx_busy_out,
    output logic                          tx_valid_out,
    output logic [DATA_SIZE+TAG_SIZE-1:0] tx_data_tag_out,
    input  logic                          ack_in,
    output logic                          tx_done_out,
    output logic                          tx_fail_out
);

    localparam int TIMER_W = $clog2(ACK_TIMEOUT) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;

    tx_state_t                     state_d, state_q;
    logic [TIMER_W-1:0]            timer_d, timer_q;
    logic [RETRY_W-1:0]            retry_d, retry_q;
    logic [DATA_SIZE+TAG_SIZE-1:0] tx_word_d, tx_word_q;
    logic                          tx_valid_d, tx_valid_q;
    logic                          tx_done_d, tx_done_q;
    logic                          tx_fail_d, tx_fail_q;
    logic [TAG_SIZE-1:0]           tx_tag;

    asp_net_tag_check #(
        .DATA_SIZE (DATA_SIZE),
        .TAG_SIZE  (TAG_SIZE)
    ) u_tag_check (
        .clk               (clk),
        .reset             (reset),
        .key_in            (key_in),
        .rx_valid_in       (rx_valid_in),
        .rx_data_tag_in    (rx_data_tag_in),
        .ack_out           (ack_out),
        .rx_data_out       (rx_data_out),
        .rx_data_valid_out (rx_data_valid_out),
        .rx_tag_error_out  (rx_tag_error_out)
    );

    // Transmit FSM next-state: latch and tag on request, strobe on entry to SEND, time out and retry in WAIT_ACK.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        tx_word_d  = tx_word_q;
        tx_valid_d = 1'b0;
        tx_done_d  = 1'b0;
        tx_fail_d  = 1'b0;
        tx_tag     = TAG_SIZE'(calc_tag(MAX_DATA_SIZE'(tx_data_in), key_in, DATA_SIZE, TAG_SIZE));
        case (state_q)
            TX_IDLE: begin
                if (tx_req_in) begin
                    tx_word_d  = {tx_data_in, tx_tag};
                    retry_d    = '0;
                    timer_d    = '0;
                    tx_valid_d = 1'b1;
                    state_d    = TX_SEND;
                end
            end
            TX_SEND: begin
                timer_d = '0;
                state_d = TX_WAIT_ACK;
            end
            TX_WAIT_ACK: begin
                if (ack_in) begin
                    tx_done_d = 1'b1;
                    retry_d   = '0;
                    timer_d   = '0;
                    state_d   = TX_IDLE;
                end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
                    timer_d = '0;
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d    = retry_q + RETRY_W'(1);
                        tx_valid_d = 1'b1;
                        state_d    = TX_SEND;
                    end else begin
                        tx_fail_d = 1'b1;
                        state_d   = TX_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Transmit state and registered outputs; a low reset abandons any transfer silently.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= TX_IDLE;
            timer_q    <= '0;
            retry_q    <= '0;
            tx_word_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_fail_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            tx_word_q  <= tx_word_d;
            tx_valid_q <= tx_valid_d;
            tx_done_q  <= tx_done_d;
            tx_fail_q  <= tx_fail_d;
        end
    end

    assign tx_busy_out     = (state_q != TX_IDLE);
    assign tx_valid_out    = tx_valid_q;
    assign tx_data_tag_out = tx_word_q;
    assign tx_done_out     = tx_done_q;
    assign tx_fail_out     = tx_fail_q;

endmodule

// File: tb/tb_asp_net_endpoint.sv
// Scoreboard bench for asp_net_endpoint: directed stimulus pushes expected pulses
// (with their cycle stamps) into queues; a negedge monitor pops and compares them.
module tb_asp_net_endpoint;

    localparam int DATA_SIZE   = 32;
    localparam int TAG_SIZE    = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int MAX_RETRY   = 3;
    localparam int W           = DATA_SIZE + TAG_SIZE;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b0;
    logic [15:0]          key_in = 16'hA55A;
    logic                 rx_valid_in = 1'b0;
    logic [W-1:0]         rx_data_tag_in = '0;
    logic                 ack_out;
    logic [DATA_SIZE-1:0] rx_data_out;
    logic                 rx_data_valid_out;
    logic                 rx_tag_error_out;
    logic                 tx_req_in = 1'b0;
    logic [DATA_SIZE-1:0] tx_data_in = '0;
    logic                 tx_busy_out;
    logic                 tx_valid_out;
    logic [W-1:0]         tx_data_tag_out;
    logic                 ack_in = 1'b0;
    logic                 tx_done_out;
    logic                 tx_fail_out;

    typedef struct {
        int                   cycle;
        logic                 is_err;
        logic [DATA_SIZE-1:0] data;
    } rx_exp_t;

    typedef struct {
        int           cycle;
        logic [W-1:0] word;
    } tx_exp_t;

    rx_exp_t rx_sb[$];
    tx_exp_t send_sb[$];
    int      done_sb[$];
    int      fail_sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n;

    asp_net_endpoint #(
        .DATA_SIZE   (DATA_SIZE),
        .TAG_SIZE    (TAG_SIZE),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .key_in            (key_in),
        .rx_valid_in       (rx_valid_in),
        .rx_data_tag_in    (rx_data_tag_in),
        .ack_out           (ack_out),
        .rx_data_out       (rx_data_out),
        .rx_data_valid_out (rx_data_valid_out),
        .rx_tag_error_out  (rx_tag_error_out),
        .tx_req_in         (tx_req_in),
        .tx_data_in        (tx_data_in),
        .tx_busy_out       (tx_busy_out),
        .tx_valid_out      (tx_valid_out),
        .tx_data_tag_out   (tx_data_tag_out),
        .ack_in            (ack_in),
        .tx_done_out       (tx_done_out),
        .tx_fail_out       (tx_fail_out)
    );

    // Free-running clock and cycle counter used to stamp expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic rxv, input logic [W-1:0] rxw, input logic req,
                                 input logic [DATA_SIZE-1:0] txd, input logic ack);
        rx_valid_in    = rxv;
        rx_data_tag_in = rxw;
        tx_req_in      = req;
        tx_data_in     = txd;
        ack_in         = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic expectRx(input int c, input logic is_err, input logic [DATA_SIZE-1:0] d);
        rx_exp_t e;
        e.cycle = c; e.is_err = is_err; e.data = d;
        rx_sb.push_back(e);
    endtask

    task automatic expectSend(input int c, input logic [W-1:0] w);
        tx_exp_t e;
        e.cycle = c; e.word = w;
        send_sb.push_back(e);
    endtask

    task automatic checkAllZero();
        checkOutput("zero_ack",      64'(ack_out),           64'(0));
        checkOutput("zero_rx_data",  64'(rx_data_out),       64'(0));
        checkOutput("zero_rx_valid", 64'(rx_data_valid_out), 64'(0));
        checkOutput("zero_rx_err",   64'(rx_tag_error_out),  64'(0));
        checkOutput("zero_busy",     64'(tx_busy_out),       64'(0));
        checkOutput("zero_tx_valid", 64'(tx_valid_out),      64'(0));
        checkOutput("zero_tx_word",  64'(tx_data_tag_out),   64'(0));
        checkOutput("zero_done",     64'(tx_done_out),       64'(0));
        checkOutput("zero_fail",     64'(tx_fail_out),       64'(0));
    endtask

    task automatic drainCheck();
        checkOutput("rx_missing",   64'(rx_sb.size()),   64'(0));
        checkOutput("send_missing", 64'(send_sb.size()), 64'(0));
        checkOutput("done_missing", 64'(done_sb.size()), 64'(0));
        checkOutput("fail_missing", 64'(fail_sb.size()), 64'(0));
        rx_sb.delete(); send_sb.delete(); done_sb.delete(); fail_sb.delete();
    endtask

    // Monitor: on every DUT output pulse pop the matching expectation and compare.
    always @(negedge clk) begin
        rx_exp_t re;
        tx_exp_t te;
        int      c;
        if (ack_out || rx_data_valid_out || rx_tag_error_out) begin
            if (rx_sb.size() == 0) begin
                checkOutput("rx_unexpected", 64'({ack_out, rx_data_valid_out, rx_tag_error_out}), 64'(0));
            end else begin
                re = rx_sb.pop_front();
                checkOutput("rx_cycle", 64'(cyc),               64'(re.cycle));
                checkOutput("rx_ack",   64'(ack_out),           64'(!re.is_err));
                checkOutput("rx_valid", 64'(rx_data_valid_out), 64'(!re.is_err));
                checkOutput("rx_err",   64'(rx_tag_error_out),  64'(re.is_err));
                checkOutput("rx_data",  64'(rx_data_out),       64'(re.data));
            end
        end
        if (tx_valid_out) begin
            if (send_sb.size() == 0) begin
                checkOutput("send_unexpected", 64'(tx_valid_out), 64'(0));
            end else begin
                te = send_sb.pop_front();
                checkOutput("send_cycle", 64'(cyc),             64'(te.cycle));
                checkOutput("send_word",  64'(tx_data_tag_out), 64'(te.word));
            end
        end
        if (tx_done_out) begin
            if (done_sb.size() == 0) begin
                checkOutput("done_unexpected", 64'(tx_done_out), 64'(0));
            end else begin
                c = done_sb.pop_front();
                checkOutput("done_cycle", 64'(cyc), 64'(c));
            end
        end
        if (tx_fail_out) begin
            if (fail_sb.size() == 0) begin
                checkOutput("fail_unexpected", 64'(tx_fail_out), 64'(0));
            end else begin
                c = fail_sb.pop_front();
                checkOutput("fail_cycle", 64'(cyc), 64'(c));
            end
        end
    end

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        // Reset state
        reset = 1'b0;
        idle(3);
        checkAllZero();
        reset = 1'b1;
        idle(2);

        // RX: good tag (12^34^56^78=08, ^A5^5A -> F7)
        expectRx(cyc + 1, 1'b0, 32'h12345678);
        applyStimulus(1'b1, {32'h12345678, 8'hF7}, 1'b0, '0, 1'b0);
        idle(2);

        // RX: bad tag on the same word, then a different word with bad tag; data holds
        expectRx(cyc + 1, 1'b1, 32'h12345678);
        applyStimulus(1'b1, {32'h12345678, 8'hF6}, 1'b0, '0, 1'b0);
        idle(1);
        expectRx(cyc + 1, 1'b1, 32'h12345678);
        applyStimulus(1'b1, {32'hDEADBEEF, 8'h00}, 1'b0, '0, 1'b0);
        idle(2);

        // RX: back-to-back good words (DEADBEEF -> DD, 00000000 -> FF)
        expectRx(cyc + 1, 1'b0, 32'hDEADBEEF);
        applyStimulus(1'b1, {32'hDEADBEEF, 8'hDD}, 1'b0, '0, 1'b0);
        expectRx(cyc + 1, 1'b0, 32'h00000000);
        applyStimulus(1'b1, {32'h00000000, 8'hFF}, 1'b0, '0, 1'b0);
        expectRx(cyc + 1, 1'b0, 32'h12345678);
        applyStimulus(1'b1, {32'h12345678, 8'hF7}, 1'b0, '0, 1'b0);
        idle(2);
        drainCheck();

        // TX: immediate ACK, concurrent RX word, then a new request on the done cycle
        n = cyc;
        expectSend(n + 1, 40'h12345678F7);
        applyStimulus(1'b0, '0, 1'b1, 32'h12345678, 1'b0);
        expectRx(n + 2, 1'b0, 32'hDEADBEEF);
        applyStimulus(1'b1, {32'hDEADBEEF, 8'hDD}, 1'b0, '0, 1'b0);
        done_sb.push_back(n + 3);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("busy_at_done", 64'(tx_busy_out), 64'(0));
        expectSend(n + 4, 40'hDEADBEEFDD);
        applyStimulus(1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
        idle(1);
        done_sb.push_back(n + 6);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(3);
        checkOutput("tx_word_held", 64'(tx_data_tag_out), 64'(40'hDEADBEEFDD));
        drainCheck();

        // TX: no ACK ever; four sends 17 cycles apart and one fail; request while busy ignored
        n = cyc;
        expectSend(n + 1,  40'h12345678F7);
        expectSend(n + 18, 40'h12345678F7);
        expectSend(n + 35, 40'h12345678F7);
        expectSend(n + 52, 40'h12345678F7);
        fail_sb.push_back(n + 69);
        applyStimulus(1'b0, '0, 1'b1, 32'h12345678, 1'b0);
        for (int i = 1; i < 75; i++) begin
            if (i == 10) checkOutput("busy_waiting", 64'(tx_busy_out), 64'(1));
            applyStimulus(1'b0, '0, (i == 5), 32'hDEADBEEF, 1'b0);
        end
        checkOutput("busy_after_fail", 64'(tx_busy_out), 64'(0));
        drainCheck();

        // TX: ACK during SEND ignored, ACK on the timeout cycle wins (no resend)
        n = cyc;
        expectSend(n + 1, 40'h12345678F7);
        done_sb.push_back(n + 18);
        applyStimulus(1'b0, '0, 1'b1, 32'h12345678, 1'b0);
        for (int i = 1; i < 21; i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, (i == 1) || (i == 17));
        end
        drainCheck();

        // Reset during WAIT_ACK: everything clears, no done/fail, no resend afterwards
        n = cyc;
        expectSend(n + 1, 40'hDEADBEEFDD);
        applyStimulus(1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
        idle(4);
        reset = 1'b0;
        idle(1);
        checkAllZero();
        idle(1);
        reset = 1'b1;
        idle(25);
        drainCheck();

        // Next request after reset completes normally
        n = cyc;
        expectSend(n + 1, 40'h12345678F7);
        applyStimulus(1'b0, '0, 1'b1, 32'h12345678, 1'b0);
        idle(1);
        done_sb.push_back(n + 3);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        idle(3);
        drainCheck();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
